// File: rtl/gmsk_pkg.sv
// gmsk_pkg: shared states, GSM burst constants and counter-width helper for the GMSK front end
package gmsk_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE, GUARD} state_t;
  localparam int BURST_BITS_NORMAL = 148;
  localparam int GUARD_SYMBOLS_NORMAL = 8;
  localparam int ROM_INDEX_BITS = 8;
  localparam logic DIFF_ENC_INIT = 1'b1;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/gmsk_strobe_gen.sv
// gmsk_strobe_gen: clock divider and sample counter producing modulator sample/symbol strobes
module gmsk_strobe_gen import gmsk_pkg::*; #(
  parameter int CLOCKS_PER_SAMPLE = 4,
  parameter int SAMPLES_PER_SYMBOL = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic i_en,
  output logic o_symbol_strobe,
  output logic o_sample_strobe,
  output logic o_last
);
  localparam int DW = cnt_w(CLOCKS_PER_SAMPLE);
  localparam int SW = cnt_w(SAMPLES_PER_SYMBOL);
  localparam logic [DW-1:0] DMAX = DW'(CLOCKS_PER_SAMPLE - 1);
  localparam logic [SW-1:0] SMAX = SW'(SAMPLES_PER_SYMBOL - 1);
  logic [DW-1:0] r_div;
  logic [SW-1:0] r_samp;
  logic w_div_wrap;
  assign w_div_wrap = r_div == DMAX;
  assign o_symbol_strobe = i_en && r_div == '0 && r_samp == '0;
  assign o_sample_strobe = i_en && w_div_wrap;
  assign o_last = i_en && w_div_wrap && r_samp == SMAX;
  // counters park at zero while disabled so each burst starts on a symbol boundary
  always_ff @(posedge clock)
    if (reset || !i_en) begin
      r_div <= '0;
      r_samp <= '0;
    end else begin
      r_div <= w_div_wrap ? '0 : r_div + DW'(1);
      if (w_div_wrap) r_samp <= r_samp == SMAX ? '0 : r_samp + SW'(1);
    end
endmodule

// File: rtl/gmsk_burst_sequencer.sv
// gmsk_burst_sequencer: burst FSM, bit fetch handshake and GSM differential encoder feeding the GMSK modulator
module gmsk_burst_sequencer import gmsk_pkg::*; #(
  parameter int CLOCKS_PER_SAMPLE = 4,
  parameter int SAMPLES_PER_SYMBOL = 2 ** ROM_INDEX_BITS,
  parameter int BURST_BITS = BURST_BITS_NORMAL,
  parameter int GUARD_SYMBOLS = GUARD_SYMBOLS_NORMAL
) (
  input  logic clock,
  input  logic reset,
  input  logic burst_start,
  input  logic in_bit,
  input  logic in_valid,
  output logic in_ready,
  output logic symbol_strobe,
  output logic sample_strobe,
  output logic output_bit,
  output logic clk_en,
  output logic burst_active,
  output logic burst_done,
  output logic underrun
);
  localparam int SW = cnt_w(BURST_BITS + GUARD_SYMBOLS);
  localparam logic [SW-1:0] LAST_DATA = SW'(BURST_BITS - 1);
  localparam logic [SW-1:0] LAST_SYM = SW'(BURST_BITS + GUARD_SYMBOLS - 1);
  state_t r_state, w_state_nxt;
  logic [SW-1:0] r_sym;
  logic r_out, r_dprev, r_done, r_underrun;
  logic w_last, w_in_ready, w_guard_bit, w_end_data, w_end_burst, w_bit;
  gmsk_strobe_gen #(
    .CLOCKS_PER_SAMPLE(CLOCKS_PER_SAMPLE),
    .SAMPLES_PER_SYMBOL(SAMPLES_PER_SYMBOL)
  ) u_strobe (
    .clock(clock),
    .reset(reset),
    .i_en(r_state == ACTIVE || r_state == GUARD),
    .o_symbol_strobe(symbol_strobe),
    .o_sample_strobe(sample_strobe),
    .o_last(w_last)
  );
  assign w_bit = in_valid ? in_bit : 1'b1;
  assign w_end_data = r_state == ACTIVE && w_last && r_sym == LAST_DATA;
  assign w_end_burst = r_state == GUARD && w_last && r_sym == LAST_SYM;
  assign in_ready = w_in_ready;
  assign output_bit = r_out;
  assign clk_en = r_state != IDLE;
  assign burst_active = r_state != IDLE;
  assign burst_done = r_done;
  assign underrun = r_underrun;
  // state register
  always_ff @(posedge clock)
    if (reset) r_state <= IDLE;
    else r_state <= w_state_nxt;
  // next state, fetch request for the coming data symbol, and guard-bit insertion
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready = 1'b0;
    w_guard_bit = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = burst_start ? LOAD : IDLE;
      LOAD: begin
        w_state_nxt = ACTIVE;
        w_in_ready = 1'b1;
      end
      ACTIVE: begin
        w_state_nxt = w_end_data ? GUARD : ACTIVE;
        w_in_ready = w_last && !w_end_data;
        w_guard_bit = w_end_data;
      end
      GUARD: begin
        w_state_nxt = w_end_burst ? IDLE : GUARD;
        w_guard_bit = w_last && !w_end_burst;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  // symbol counter, differential encoder, underrun flag and end-of-burst pulse
  always_ff @(posedge clock)
    if (reset) begin
      r_sym <= '0;
      r_out <= 1'b0;
      r_dprev <= DIFF_ENC_INIT;
      r_done <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_done <= w_end_burst;
      r_sym <= (r_state == LOAD || w_end_burst) ? '0 : w_last ? r_sym + SW'(1) : r_sym;
      if (r_state == IDLE && burst_start) begin
        r_underrun <= 1'b0;
        r_dprev <= DIFF_ENC_INIT;
      end
      if (w_in_ready) begin
        r_out <= w_bit ^ r_dprev;
        r_dprev <= w_bit;
        if (!in_valid) r_underrun <= 1'b1;
      end
      if (w_guard_bit) begin
        r_out <= ~r_dprev;
        r_dprev <= 1'b1;
      end
    end
endmodule

// File: tb/tb_gmsk_burst_sequencer.sv
// tb_gmsk_burst_sequencer: scoreboard bench for the GMSK burst sequencer on a shrunk burst geometry
module tb_gmsk_burst_sequencer;
  localparam int CPS = 2, SPS = 4, BB = 4, GS = 2;
  localparam int SYM_LEN = CPS * SPS;
  logic clock = 1'b0, reset = 1'b1, burst_start = 1'b0;
  logic in_bit, in_valid, in_ready, symbol_strobe, sample_strobe, output_bit;
  logic clk_en, burst_active, burst_done, underrun;
  int cyc = 0, ur_cyc = -1, errors = 0, checks = 0;
  int nsym = 0, nsamp = 0, last_sym = 0, base_sym, base_samp;
  logic stim [64];
  logic [5:0] wp = '0, idx = '0;
  int q_sym [$], q_rdy [$], q_done [$];
  logic q_bit [$];

  gmsk_burst_sequencer #(
    .CLOCKS_PER_SAMPLE(CPS), .SAMPLES_PER_SYMBOL(SPS), .BURST_BITS(BB), .GUARD_SYMBOLS(GS)
  ) dut (
    .clock(clock), .reset(reset), .burst_start(burst_start), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready), .symbol_strobe(symbol_strobe), .sample_strobe(sample_strobe),
    .output_bit(output_bit), .clk_en(clk_en), .burst_active(burst_active),
    .burst_done(burst_done), .underrun(underrun)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign in_bit = stim[idx];
  assign in_valid = cyc != ur_cyc;
  always @(posedge clock)
    if (reset) idx <= wp;
    else if (in_ready) idx <= idx + 6'd1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", tag, cyc, act, exp);
    end
  endtask

  task automatic go(input int t);
    while (cyc < t) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic sb_burst(input int t0, input logic [3:0] b, input int u);
    logic d, x;
    d = 1'b1;
    for (int k = 0; k < BB; k++) begin
      stim[wp] = b[3-k];
      wp = wp + 6'd1;
      q_rdy.push_back(t0 + 1 + k * SYM_LEN);
    end
    for (int k = 0; k < BB + GS; k++) begin
      x = (k < BB && k != u) ? b[3-k] : 1'b1;
      q_sym.push_back(t0 + 2 + k * SYM_LEN);
      q_bit.push_back(x ^ d);
      d = x;
    end
    q_done.push_back(t0 + 2 + (BB + GS) * SYM_LEN);
    ur_cyc = u >= 0 ? t0 + 1 + u * SYM_LEN : -1;
  endtask

  always @(negedge clock)
    if (!reset) begin
      if (symbol_strobe) begin
        nsym++;
        last_sym = cyc;
        if (q_sym.size() == 0) chk("sym_extra", 1, 0);
        else begin
          chk("sym_cyc", cyc, q_sym.pop_front());
          chk("out_bit", output_bit, q_bit.pop_front());
        end
      end
      if (sample_strobe) begin
        nsamp++;
        chk("coincide", symbol_strobe, 0);
        chk("samp_phase", (cyc - last_sym) % 2, 1);
      end
      if (in_ready) begin
        if (q_rdy.size() == 0) chk("rdy_extra", 1, 0);
        else chk("rdy_cyc", cyc, q_rdy.pop_front());
      end
      if (burst_done) begin
        if (q_done.size() == 0) chk("done_extra", 1, 0);
        else chk("done_cyc", cyc, q_done.pop_front());
      end
    end

  function automatic logic [7:0] outs();
    return {in_ready, symbol_strobe, sample_strobe, output_bit, clk_en, burst_active, burst_done, underrun};
  endfunction

  initial begin
    go(3);
    chk("reset_outs", outs(), 0);
    reset = 1'b0;
    // nominal burst with an ignored second start mid-burst
    go(5);
    base_sym = nsym;
    base_samp = nsamp;
    sb_burst(5, 4'b1001, -1);
    burst_start = 1'b1;
    go(6);
    burst_start = 1'b0;
    chk("clk_en_load", clk_en, 1);
    chk("active_load", burst_active, 1);
    go(25);
    burst_start = 1'b1;
    go(26);
    burst_start = 1'b0;
    go(54);
    chk("clk_en_last", clk_en, 1);
    // back-to-back start on the burst_done cycle, with an underrun on the third bit
    go(55);
    chk("clk_en_idle", clk_en, 0);
    chk("done_pulse", burst_done, 1);
    chk("no_underrun", underrun, 0);
    chk("sym_count", nsym - base_sym, BB + GS);
    chk("samp_count", nsamp - base_samp, (BB + GS) * SPS);
    sb_burst(55, 4'b1001, 2);
    stim[wp - 6'd2] = 1'b0;
    burst_start = 1'b1;
    go(56);
    burst_start = 1'b0;
    chk("b2b_load", clk_en, 1);
    go(72);
    chk("underrun_before", underrun, 0);
    go(73);
    chk("underrun_set", underrun, 1);
    go(105);
    chk("underrun_at_done", underrun, 1);
    go(106);
    chk("underrun_hold", underrun, 1);
    chk("done_single", burst_done, 0);
    // next burst clears underrun, then gets reset mid-burst
    go(110);
    sb_burst(110, 4'b0110, -1);
    burst_start = 1'b1;
    go(111);
    burst_start = 1'b0;
    chk("underrun_clear", underrun, 0);
    go(130);
    reset = 1'b1;
    q_sym.delete();
    q_bit.delete();
    q_rdy.delete();
    q_done.delete();
    go(131);
    chk("abort_outs", outs(), 0);
    reset = 1'b0;
    go(132);
    chk("abort_idle", outs(), 0);
    // a fresh nominal burst after the abort
    go(140);
    sb_burst(140, 4'b1001, -1);
    burst_start = 1'b1;
    go(141);
    burst_start = 1'b0;
    go(195);
    chk("final_out", output_bit, 0);
    chk("final_idle", clk_en, 0);
    chk("left_sym", q_sym.size(), 0);
    chk("left_rdy", q_rdy.size(), 0);
    chk("left_done", q_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
